// File: rtl/occupancy_pkg.sv
// rtl/occupancy_pkg.sv - shared types, default parameters and log-odds helper for the occupancy updater
package occupancy_pkg;

  localparam int COORD_W_DEF = 8;
  localparam int CELL_W_DEF  = 8;
  localparam int LO_OCC_DEF  = 7;
  localparam int LO_FREE_DEF = 2;

  typedef logic signed [CELL_W_DEF-1:0] cell_t;
  typedef logic [2*COORD_W_DEF-1:0]     addr_t;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    CLEAR
  } state_t;

  // Symmetric range: the most negative code is never produced.
  localparam cell_t LO_MAX = cell_t'((1 << (CELL_W_DEF-1)) - 1);
  localparam cell_t LO_MIN = -LO_MAX;

  function automatic cell_t sat_update(input cell_t old, input logic is_free);
    logic signed [CELL_W_DEF:0] ext;
    logic signed [CELL_W_DEF:0] delta;
    logic signed [CELL_W_DEF:0] sum;
    ext   = {old[CELL_W_DEF-1], old};
    delta = is_free ? -(CELL_W_DEF+1)'(LO_FREE_DEF) : (CELL_W_DEF+1)'(LO_OCC_DEF);
    sum   = ext + delta;
    if (sum > {LO_MAX[CELL_W_DEF-1], LO_MAX}) begin
      return LO_MAX;
    end else if (sum < {LO_MIN[CELL_W_DEF-1], LO_MIN}) begin
      return LO_MIN;
    end
    return sum[CELL_W_DEF-1:0];
  endfunction

endpackage

// File: rtl/occupancy_updater_if.sv
// rtl/occupancy_updater_if.sv - occupancy-grid RAM port bundle (updater drives, RAM responds)
interface occupancy_updater_if #(
  parameter int AW = 16,
  parameter int DW = 8
);
  logic [AW-1:0]        ram_raddr;
  logic signed [DW-1:0] ram_rdata;
  logic [AW-1:0]        ram_waddr;
  logic signed [DW-1:0] ram_wdata;
  logic                 ram_we;

  modport master (
    output ram_raddr,
    output ram_waddr,
    output ram_wdata,
    output ram_we,
    input  ram_rdata
  );

  modport slave (
    input  ram_raddr,
    input  ram_waddr,
    input  ram_wdata,
    input  ram_we,
    output ram_rdata
  );
endinterface

// File: rtl/occupancy_sat_add.sv
// rtl/occupancy_sat_add.sv - combinational log-odds delta with symmetric saturation
module occupancy_sat_add
  import occupancy_pkg::*;
#(
  parameter int CELL_W  = CELL_W_DEF,
  parameter int LO_OCC  = LO_OCC_DEF,
  parameter int LO_FREE = LO_FREE_DEF
) (
  input  logic signed [CELL_W-1:0] old_i,
  input  logic                     is_free_i,
  output logic signed [CELL_W-1:0] new_o
);
  localparam logic signed [CELL_W:0] MAX_W  = (CELL_W+1)'((1 << (CELL_W-1)) - 1);
  localparam logic signed [CELL_W:0] MIN_W  = -MAX_W;
  localparam logic signed [CELL_W:0] OCC_W  = (CELL_W+1)'(LO_OCC);
  localparam logic signed [CELL_W:0] FREE_W = (CELL_W+1)'(LO_FREE);

  logic signed [CELL_W:0] sum_w;

  // One extra bit of headroom so the clamp sees the true sum.
  always_comb begin
    sum_w = $signed({old_i[CELL_W-1], old_i}) + (is_free_i ? -FREE_W : OCC_W);
    if (sum_w > MAX_W) begin
      new_o = MAX_W[CELL_W-1:0];
    end else if (sum_w < MIN_W) begin
      new_o = MIN_W[CELL_W-1:0];
    end else begin
      new_o = sum_w[CELL_W-1:0];
    end
  end
endmodule

// File: rtl/occupancy_updater.sv
// rtl/occupancy_updater.sv - 2-stage log-odds RMW pipeline with forwarding and full-map clear
// Optional: OCCUPANCY_DROP_COUNT_EN adds a saturating count of requests dropped while busy.
module occupancy_updater
  import occupancy_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF,
  parameter int CELL_W  = CELL_W_DEF,
  parameter int LO_OCC  = LO_OCC_DEF,
  parameter int LO_FREE = LO_FREE_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               write_enable,
  input  logic               cell_is_free,
  input  logic [COORD_W-1:0] cell_x,
  input  logic [COORD_W-1:0] cell_y,
  input  logic               clear,
  occupancy_updater_if.master ram,
  output logic               busy
`ifdef OCCUPANCY_DROP_COUNT_EN
  ,
  output logic [15:0]        drop_count
`endif
);
  localparam int AW = 2*COORD_W;
  localparam logic [AW-1:0] LAST_ADDR = '1;

  state_t state_q, state_d;
  logic   busy_q, busy_d;

  logic              s1_valid_q, s1_valid_d;
  logic [AW-1:0]     s1_addr_q, s1_addr_d;
  logic              s1_free_q, s1_free_d;

  // S2 doubles as the RAM write port register.
  logic                     we_q, we_d;
  logic [AW-1:0]            waddr_q, waddr_d;
  logic signed [CELL_W-1:0] wdata_q, wdata_d;

  logic                     w_valid_q, w_valid_d;
  logic [AW-1:0]            w_addr_q, w_addr_d;
  logic signed [CELL_W-1:0] w_data_q, w_data_d;

  logic                     accept_w;
  logic [AW-1:0]            req_addr_w;
  logic signed [CELL_W-1:0] old_w;
  logic signed [CELL_W-1:0] new_w;

  assign accept_w   = write_enable && (state_q == IDLE);
  assign req_addr_w = {cell_y, cell_x};

  // RAM read-during-write returns stale data, so the two most recent writes are bypassed.
  always_comb begin
    if (we_q && (waddr_q == s1_addr_q)) begin
      old_w = wdata_q;
    end else if (w_valid_q && (w_addr_q == s1_addr_q)) begin
      old_w = w_data_q;
    end else begin
      old_w = ram.ram_rdata;
    end
  end

  occupancy_sat_add #(
    .CELL_W (CELL_W),
    .LO_OCC (LO_OCC),
    .LO_FREE(LO_FREE)
  ) u_sat_add (
    .old_i    (old_w),
    .is_free_i(s1_free_q),
    .new_o    (new_w)
  );

  always_comb begin
    state_d    = state_q;
    s1_valid_d = accept_w;
    s1_addr_d  = req_addr_w;
    s1_free_d  = cell_is_free;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    w_valid_d  = we_q;
    w_addr_d   = waddr_q;
    w_data_d   = wdata_q;

    if (s1_valid_q) begin
      we_d    = 1'b1;
      waddr_d = s1_addr_q;
      wdata_d = new_w;
    end

    case (state_q)
      IDLE: begin
        if (clear) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!s1_valid_q && !we_q) begin
          state_d = CLEAR;
          we_d    = 1'b1;
          waddr_d = '0;
          wdata_d = '0;
        end
      end
      CLEAR: begin
        if (waddr_q == LAST_ADDR) begin
          state_d = IDLE;
        end else begin
          we_d    = 1'b1;
          waddr_d = waddr_q + 1'b1;
          wdata_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_free_q  <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      w_valid_q  <= 1'b0;
      w_addr_q   <= '0;
      w_data_q   <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      s1_valid_q <= s1_valid_d;
      s1_addr_q  <= s1_addr_d;
      s1_free_q  <= s1_free_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      w_valid_q  <= w_valid_d;
      w_addr_q   <= w_addr_d;
      w_data_q   <= w_data_d;
    end
  end

  assign ram.ram_raddr = req_addr_w;
  assign ram.ram_we    = we_q;
  assign ram.ram_waddr = waddr_q;
  assign ram.ram_wdata = wdata_q;
  assign busy          = busy_q;

`ifdef OCCUPANCY_DROP_COUNT_EN
  logic [15:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (write_enable && (state_q != IDLE) && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign drop_count = drop_q;
`endif

endmodule

// File: tb/tb_occupancy_updater.sv
// tb/tb_occupancy_updater.sv - randomized self-checking bench for occupancy_updater (COORD_W=4)
module tb_occupancy_updater;
  localparam int CW    = 4;
  localparam int NCELL = 256;
  localparam int CMAX  = 127;

  logic          clock = 1'b0;
  logic          reset;
  logic          write_enable;
  logic          cell_is_free;
  logic [CW-1:0] cell_x;
  logic [CW-1:0] cell_y;
  logic          clear;
  logic          busy;
`ifdef OCCUPANCY_DROP_COUNT_EN
  logic [15:0]   drop_count;
`endif

  occupancy_updater_if #(.AW(2*CW), .DW(8)) ram_bus ();

  occupancy_updater #(.COORD_W(CW)) dut (
    .clock       (clock),
    .reset       (reset),
    .write_enable(write_enable),
    .cell_is_free(cell_is_free),
    .cell_x      (cell_x),
    .cell_y      (cell_y),
    .clear       (clear),
    .ram         (ram_bus),
    .busy        (busy)
`ifdef OCCUPANCY_DROP_COUNT_EN
    ,
    .drop_count  (drop_count)
`endif
  );

  always #5 clock = ~clock;

  // Behavioural RAM: 1-cycle read, read-during-write returns old data.
  logic signed [7:0] mem [NCELL];
  int                init_pat [NCELL];
  logic              load_en = 1'b0;
  logic              poke_en = 1'b0;
  logic [7:0]        poke_addr = '0;
  logic [7:0]        poke_data = '0;

  always @(posedge clock) begin
    ram_bus.ram_rdata <= mem[ram_bus.ram_raddr];
    if (load_en) begin
      for (int i = 0; i < NCELL; i++) mem[i] <= 8'(init_pat[i]);
    end else if (poke_en) begin
      mem[poke_addr] <= poke_data;
    end
    if (ram_bus.ram_we) mem[ram_bus.ram_waddr] <= ram_bus.ram_wdata;
  end

  typedef struct {
    int addr;
    int data;
    int due;
    bit is_clr;
  } wr_t;

  wr_t expq[$];
  int  model_map [NCELL];
  bit  model_busy = 1'b0;
  int  drops_model = 0;
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  clr_first = -1;
  int  clr_last = -1;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int model_update(input int a, input bit free);
    int v;
    v = model_map[a] + (free ? -2 : 7);
    if (v > CMAX) v = CMAX;
    if (v < -CMAX) v = -CMAX;
    model_map[a] = v;
    return v;
  endfunction

  task automatic tick();
    wr_t e;
    @(negedge clock);
    cyc++;
    if (ram_bus.ram_we) begin
      if (expq.size() == 0) begin
        check("spurious_we", 1, 0);
      end else begin
        e = expq.pop_front();
        check("wr_addr", int'(ram_bus.ram_waddr), e.addr);
        check("wr_data", int'(ram_bus.ram_wdata), e.data);
        if (!e.is_clr) begin
          check("upd_latency", cyc, e.due);
        end else begin
          if (e.addr == 0) clr_first = cyc;
          if (e.addr == NCELL - 1) begin
            clr_last = cyc;
            check("busy_at_last_clear", int'(busy), 1);
          end
        end
      end
    end else if (expq.size() > 0 && !expq[0].is_clr && cyc >= expq[0].due) begin
      check("missing_we", 0, 1);
      void'(expq.pop_front());
    end
  endtask

  task automatic idle();
    write_enable = 1'b0;
    clear        = 1'b0;
  endtask

  task automatic req(input int x, input int y, input bit free, input bit clr);
    int a;
    int v;
    write_enable = 1'b1;
    cell_x       = 4'(x);
    cell_y       = 4'(y);
    cell_is_free = free;
    clear        = clr;
    if (!model_busy) begin
      a = y * 16 + x;
      v = model_update(a, free);
      expq.push_back('{a, v, cyc + 2, 1'b0});
      #1 check("raddr", int'(ram_bus.ram_raddr), a);
    end else begin
      drops_model++;
    end
  endtask

  task automatic start_clear(input int n);
    for (int i = 0; i < n; i++) begin
      expq.push_back('{i, 0, -1, 1'b1});
      model_map[i] = 0;
    end
    model_busy = 1'b1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (expq.size() > 0 && n < 600) begin
      tick();
      n++;
    end
    if (expq.size() > 0) begin
      check("drain_timeout", expq.size(), 0);
      expq.delete();
    end
    tick();
  endtask

  task automatic load_mem();
    load_en = 1'b1;
    tick();
    load_en = 1'b0;
    for (int i = 0; i < NCELL; i++) model_map[i] = init_pat[i];
  endtask

  task automatic poke(input int a, input int v);
    poke_en   = 1'b1;
    poke_addr = 8'(a);
    poke_data = 8'(v);
    tick();
    poke_en = 1'b0;
    model_map[a] = v;
  endtask

  task automatic mem_compare(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < NCELL; i++) begin
      if (int'(mem[i]) != model_map[i]) bad++;
    end
    check(tag, bad, 0);
  endtask

  task automatic check_drops();
`ifdef OCCUPANCY_DROP_COUNT_EN
    check("drop_count", int'(drop_count), drops_model);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b0;
    idle();
    cell_is_free = 1'b0;
    cell_x = '0;
    cell_y = '0;
    for (int i = 0; i < NCELL; i++) init_pat[i] = 0;
    load_en = 1'b1;
    repeat (3) tick();
    load_en = 1'b0;
    for (int i = 0; i < NCELL; i++) model_map[i] = 0;
    check("rst_we", int'(ram_bus.ram_we), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_waddr", int'(ram_bus.ram_waddr), 0);
    check("rst_wdata", int'(ram_bus.ram_wdata), 0);
    check_drops();
    reset = 1'b1;
    tick();

    // Single occupied hit, then three back-to-back to the same cell.
    req(3, 5, 1'b0, 1'b0); tick(); idle(); tick(); tick();
    check("busy_idle", int'(busy), 0);
    wait_drain();
    for (int i = 0; i < 3; i++) begin req(3, 5, 1'b0, 1'b0); tick(); end
    idle(); wait_drain();

    // A, B, A exercises the one-write-old bypass.
    req(1, 1, 1'b0, 1'b0); tick();
    req(2, 2, 1'b1, 1'b0); tick();
    req(1, 1, 1'b0, 1'b0); tick();
    idle(); wait_drain();

    // Saturation corners.
    poke(8'h77, 125);  req(7, 7, 1'b0, 1'b0); tick(); idle(); wait_drain();
    poke(8'h88, -126); req(8, 8, 1'b1, 1'b0); tick(); idle(); wait_drain();
    poke(8'h99, 127);  req(9, 9, 1'b0, 1'b0); tick(); idle(); wait_drain();
    mem_compare("mem_directed");

    // Random traffic on a tiny window of cells for heavy address reuse.
    for (int i = 0; i < NCELL; i++) init_pat[i] = int'($urandom_range(0, 254)) - 127;
    load_mem();
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 3) != 0)
        req(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
      else
        idle();
      tick();
    end
    idle(); wait_drain();
    mem_compare("mem_random");

    // Clear with requests in flight, a same-cycle request, drops and an ignored pulse.
    req(1, 2, 1'b0, 1'b0); tick();
    req(3, 3, 1'b1, 1'b1);
    start_clear(NCELL);
    tick();
    check("busy_after_clear", int'(busy), 1);
    n = 0;
    while (expq.size() > 0 && n < 400) begin
      if (n == 1 || n == 100) req(5, 5, 1'b0, 1'b0);
      else if (n == 3) begin idle(); clear = 1'b1; end
      else idle();
      tick();
      n++;
    end
    idle();
    if (expq.size() > 0) begin
      check("clear_timeout", expq.size(), 0);
      expq.delete();
    end
    check("clear_span", clr_last - clr_first, NCELL - 1);
    tick();
    model_busy = 1'b0;
    check("busy_after_sweep", int'(busy), 0);
    check_drops();
    mem_compare("mem_cleared");

    // Reset aborts a sweep: cells past the last landed write keep their contents.
    for (int i = 0; i < NCELL; i++) init_pat[i] = int'($urandom_range(1, 100));
    load_mem();
    clear = 1'b1;
    start_clear(40);
    tick();
    idle();
    n = 0;
    while (!(ram_bus.ram_we && int'(ram_bus.ram_waddr) == 39) && n < 400) begin
      tick();
      n++;
    end
    reset = 1'b0;
    tick();
    check("abort_we", int'(ram_bus.ram_we), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_queue", expq.size(), 0);
    expq.delete();
    reset = 1'b1;
    model_busy = 1'b0;
    drops_model = 0;
    tick();
    check_drops();
    mem_compare("mem_partial");

    // Updates resume normally after the aborted sweep.
    req(10, 12, 1'b0, 1'b0); tick();
    req(10, 12, 1'b1, 1'b0); tick();
    idle(); wait_drain();
    mem_compare("mem_final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
